frc_arbiter: RTL and testbench
==============================

Name: frc_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one fraction-check unit between N_REQ requesters.
- The fraction-check unit tests whether an IEEE-754 single has a zero fractional part. It has a start/done handshake: a one-cycle start pulse, then a one-cycle done pulse with the result valid in that cycle.
- frc_arbiter sits between the requesters and the check unit. It selects one request, latches its operand, drives the checker's start, waits for done, and returns the result with a one-cycle ack to the winner.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 32, operand width.
- TIMEOUT, 15, max cycles in WAIT before abort (used only with FRC_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester request level.
- num_in  in  N_REQ*W  operands; slice i = num_in[i*W +: W].
- ack  out  N_REQ  one-hot, one-cycle completion pulse to the granted requester.
- res_out  out  1  check result; valid when any ack bit is 1, holds its value until the next ack.
- err  out  1  abort flag, valid with ack; constant 0 without FRC_TIMEOUT_EN.
- busy  out  1  high in every state except IDLE.
- chk_num  out  W  operand to checker, registered at grant, stable until next grant.
- chk_start  out  1  one-cycle start pulse to checker.
- chk_done  in  1  checker done pulse.
- chk_res  in  1  checker result, sampled only when chk_done=1 in WAIT.

Behaviour:
- Reset (async, immediate) drives:
  - state=IDLE, ptr=0, grant=0;
  - ack=0, res_out=0, err=0, busy=0;
  - chk_start=0, chk_num=0, timeout counter=0.
- Reset mid-operation discards the in-flight check; no ack is produced for it.
- State register is 2 bits: IDLE=0, ISSUE=1, WAIT=2, RESP=3.
- IDLE:
  - If req != 0, select the first set bit searching from index ptr upward, wrapping modulo N_REQ.
  - Register grant index g and chk_num <= num_in slice g; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: chk_start=1 for exactly this cycle; go to WAIT.
- WAIT:
  - On chk_done=1, latch chk_res into the result register and go to RESP.
  - chk_done in any other state is ignored.
- RESP:
  - ack[g]=1 and res_out=latched result.
  - ptr <= (g+1) mod N_REQ; go to IDLE.
- All outputs are decoded from registers (no combinational path from req or chk_done to outputs).
- Latency with a checker responding k cycles after start:
  - req sampled at cycle 0; chk_start at cycle 1; ack at cycle 2+k.
  - Minimum request-to-request throughput is 3+k cycles.
- Requester rules:
  - Requester must hold req and num_in stable until the cycle it is granted. The operand is latched at grant, so num_in may change afterwards.
  - req still high in the cycle after ack is a new request. It is arbitrated with the rotated priority, so another pending requester wins first.
- req deasserted before grant is a withdrawal and is legal; req deasserted after grant is ignored and ack is still delivered.
- Simultaneous requests: strictly one grant; round-robin guarantees each pending requester is served within N_REQ transactions.
- Single requester with continuous req: served back-to-back, ptr advances but grant stays on it.
- Widths:
  - ptr and g are clog2(N_REQ) bits, minimum 1.
  - Wrap uses compare-to-N_REQ-1, not power-of-two truncation.

Optional Feature:
- Macro: FRC_TIMEOUT_EN.
- Defined:
  - A counter cleared on entry to WAIT increments each WAIT cycle.
  - If it reaches TIMEOUT without chk_done, go to RESP with res_out=0 and err=1.
  - err is 0 on normal completion.
  - A late chk_done arriving after the abort is ignored.
- Undefined: no counter; WAIT is held indefinitely; err tied 0.

Test Plan:
- Reset mid-WAIT: assert rst with the checker model delayed; then release. Required: outputs 0 and state IDLE immediately; no ack for the aborted transaction; the checker's late done is ignored.
- Single request: req=4'b0001, num=0x40400000 (3.0), checker model returns res=1 after 2 cycles. Required: chk_start at cycle 1, chk_num=0x40400000, ack=4'b0001 with res_out=1 at cycle 4.
- Result 0: req=4'b0100, num=0x40200000 (2.5), model res=0. Required: ack=4'b0100, res_out=0, err=0.
- Fairness: req=4'b1111 held continuously, ptr=0 after reset. Required: ack order 0001, 0010, 0100, 1000, 0001; exactly one ack bit per transaction.
- Withdrawal: req[2] pulsed 1 cycle while granted to requester 0. Required: req[2] never acked; busy stays high through requester 0's transaction only.
- FRC_TIMEOUT_EN, TIMEOUT=15: checker never responds. Required: ack 17 cycles after grant (ISSUE + 15 WAIT + RESP) with err=1 and res_out=0; next request is served normally.

Source files
------------

// File: rtl/frc_arbiter.sv
// Round-robin arbiter sharing one fraction-check unit between N_REQ requesters.
// Define FRC_TIMEOUT_EN to abort a check that has no done after TIMEOUT cycles.
module frc_arbiter #(
   parameter int N_REQ   = 4,
   parameter int W       = 32,
   parameter int TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*W-1:0] num_in,
   output logic [N_REQ-1:0]   ack,
   output logic               res_out,
   output logic               err,
   output logic               busy,
   output logic [W-1:0]       chk_num,
   output logic               chk_start,
   input  logic               chk_done,
   input  logic               chk_res
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [PW-1:0] LAST = PW'(N_REQ - 1);

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
      $error("frc_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t        state;
   logic [PW-1:0] ptr;
   logic [PW-1:0] grant;
   logic          found;
   logic [PW-1:0] pick;
   logic [W-1:0]  pick_num;
   logic          done_ok;
   logic          abort;

   // First set request at or after ptr, wrapping at N_REQ-1.
   always_comb begin
      int j;
      logic [PW-1:0] idx;
      j     = 0;
      idx   = '0;
      found = 1'b0;
      pick  = ptr;
      for (int i = 0; i < N_REQ; i++) begin
         j = int'(ptr) + i;
         if (j > N_REQ - 1) j = j - N_REQ;
         idx = PW'(j);
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      pick_num = '0;
      for (int i = 0; i < N_REQ; i++)
         if (PW'(i) == pick) pick_num = num_in[i*W +: W];
   end

`ifdef FRC_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CLAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt;
   logic          err_q;

   assign abort = !chk_done && (cnt == CLAST);
   assign err   = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         err_q <= 1'b0;
      end else if (state == ISSUE) begin
         cnt <= '0;
      end else if (state == WAIT) begin
         if (chk_done) err_q <= 1'b0;
         else if (abort) err_q <= 1'b1;
         else cnt <= cnt + 1'b1;
      end
   end
`else
   assign abort = 1'b0;
   assign err   = 1'b0;
`endif

   assign done_ok = chk_done || abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         grant     <= '0;
         ack       <= '0;
         res_out   <= 1'b0;
         busy      <= 1'b0;
         chk_start <= 1'b0;
         chk_num   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (found) begin
                  grant     <= pick;
                  chk_num   <= pick_num;
                  chk_start <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               chk_start <= 1'b0;
               state     <= WAIT;
            end
            WAIT: begin
               if (done_ok) begin
                  // An aborted check reports a zero result.
                  res_out <= chk_done ? chk_res : 1'b0;
                  ack     <= N_REQ'(1) << grant;
                  state   <= RESP;
               end
            end
            RESP: begin
               ack   <= '0;
               busy  <= 1'b0;
               ptr   <= (grant == LAST) ? '0 : grant + 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frc_arbiter.sv
// Scoreboard bench for frc_arbiter with a delayed fraction-check model.
// Expected acks are queued at stimulus time and popped when ack fires.
module tb_frc_arbiter;

   localparam int N = 4;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] num_in;
   logic [N-1:0]   ack;
   logic           res_out;
   logic           err;
   logic           busy;
   logic [W-1:0]   chk_num;
   logic           chk_start;
   logic           chk_done;
   logic           chk_res;

   frc_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .req(req), .num_in(num_in),
      .ack(ack), .res_out(res_out), .err(err), .busy(busy),
      .chk_num(chk_num), .chk_start(chk_start),
      .chk_done(chk_done), .chk_res(chk_res)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [N-1:0] ack;
      logic         res;
      logic         err;
      int           t0;
      int           lat;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   m_cnt = 0;
   int   m_delay = 2;
   logic m_res = 1'b1;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [N-1:0] a, input logic r,
                       input logic e, input int lat);
      exp_t x;
      x.ack = a;
      x.res = r;
      x.err = e;
      x.t0  = cyc;
      x.lat = lat;
      sb.push_back(x);
   endtask

   // Checker model: done pulse m_delay cycles after start; 0 = never.
   task automatic model();
      chk_done = 1'b0;
      if (chk_start) m_cnt = m_delay;
      else if (m_cnt > 0) begin
         m_cnt--;
         if (m_cnt == 0) chk_done = 1'b1;
      end
      chk_res = chk_done ? m_res : ~m_res;
   endtask

   task automatic monitor();
      exp_t e;
      if (ack != '0) begin
         check("ack_onehot", $countones(ack), 1);
         if (sb.size() == 0) check("unexpected_ack", ack, 0);
         else begin
            e = sb.pop_front();
            check("ack", ack, e.ack);
            check("res_out", res_out, e.res);
            check("err", err, e.err);
            if (e.lat >= 0) check("latency", cyc - e.t0, e.lat);
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      model();
      monitor();
   endtask

   task automatic drain(input int max);
      for (int i = 0; i < max && sb.size() != 0; i++) step();
      check("drain", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      req = '0;
      num_in = '0;
      chk_done = 1'b0;
      chk_res = 1'b0;
      #1;
      check("rst_ack", ack, 0);
      check("rst_busy", busy, 0);
      check("rst_start", chk_start, 0);
      check("rst_num", chk_num, 0);
      check("rst_res", res_out, 0);
      check("rst_err", err, 0);
      step();
      step();
      rst = 1'b0;
      step();

      // single request, 3.0, k=2
      num_in[0*W +: W] = 32'h4040_0000;
      m_delay = 2;
      m_res = 1'b1;
      req = 4'b0001;
      push(4'b0001, 1'b1, 1'b0, 4);
      check("start_c0", chk_start, 0);
      step();
      check("start_c1", chk_start, 1);
      check("chk_num", chk_num, 32'h4040_0000);
      check("busy_c1", busy, 1);
      req = '0;
      step();
      check("start_c2", chk_start, 0);
      drain(20);
      step();
      check("busy_idle", busy, 0);

      // result 0, 2.5, k=3
      num_in[2*W +: W] = 32'h4020_0000;
      m_delay = 3;
      m_res = 1'b0;
      req = 4'b0100;
      push(4'b0100, 1'b0, 1'b0, 5);
      step();
      check("chk_num2", chk_num, 32'h4020_0000);
      req = '0;
      drain(20);
      step();

      // fairness from ptr=0
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      m_delay = 1;
      m_res = 1'b1;
      req = 4'b1111;
      push(4'b0001, 1'b1, 1'b0, -1);
      push(4'b0010, 1'b1, 1'b0, -1);
      push(4'b0100, 1'b1, 1'b0, -1);
      push(4'b1000, 1'b1, 1'b0, -1);
      push(4'b0001, 1'b1, 1'b0, -1);
      for (int i = 0; i < 60 && sb.size() != 0; i++) step();
      req = '0;
      check("fair_drain", sb.size(), 0);
      repeat (5) step();
      check("fair_idle", busy, 0);

      // withdrawal of req[2] while requester 0 is served
      m_delay = 2;
      m_res = 1'b1;
      req = 4'b0001;
      push(4'b0001, 1'b1, 1'b0, 4);
      step();
      req = 4'b0100;
      step();
      req = '0;
      check("wd_busy_c2", busy, 1);
      for (int i = 0; i < 20 && sb.size() != 0; i++) begin
         step();
         check("wd_busy", busy, 1);
      end
      check("wd_drain", sb.size(), 0);
      for (int i = 0; i < 6; i++) begin
         step();
         check("wd_idle", busy, 0);
      end

      // reset mid-WAIT, late done must be ignored
      m_delay = 6;
      req = 4'b0010;
      step();
      req = '0;
      step();
      step();
      check("mid_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("mr_busy", busy, 0);
      check("mr_ack", ack, 0);
      check("mr_start", chk_start, 0);
      check("mr_num", chk_num, 0);
      check("mr_res", res_out, 0);
      check("mr_err", err, 0);
      step();
      step();
      rst = 1'b0;
      repeat (8) step();
      check("mr_idle", busy, 0);
      check("mr_res2", res_out, 0);

`ifdef FRC_TIMEOUT_EN
      m_delay = 0;
      req = 4'b0010;
      push(4'b0010, 1'b0, 1'b1, 17);
      step();
      req = '0;
      drain(40);
      step();
      m_delay = 2;
      m_res = 1'b1;
      req = 4'b1000;
      push(4'b1000, 1'b1, 1'b0, 4);
      step();
      req = '0;
      drain(20);
      step();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
